// File: rtl/traffic_light_controller.sv
// traffic_light_controller: highway/farm/pedestrian intersection sequencer driving the seconds timer strobe
module traffic_light_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       ped_req,
  input  logic       ts,
  input  logic       tl,
  output logic       st,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic       walk,
  output logic       ped_wait
);
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  typedef enum logic [2:0] {HG, HY, FG, FY, PW} state_t;
  state_t state_q, state_d;
  logic car_m_q, car_s_q, ped_m_q, ped_s_q, ped_p_q;
  logic pend_q, pend_d, st_q, walk_q, walk_d;
  logic [1:0] blank_q, blank_d, hwy_q, hwy_d, farm_q, farm_d;
  logic ts_ok, tl_ok, ped_rise, trans;
  // timeout levels are masked while the timer is still clearing after a strobe
  assign ts_ok    = ts & ~|blank_q;
  assign tl_ok    = tl & ~|blank_q;
  assign ped_rise = ped_s_q & ~ped_p_q;
  assign trans    = state_d != state_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HG;
      car_m_q <= 1'b0;
      car_s_q <= 1'b0;
      ped_m_q <= 1'b0;
      ped_s_q <= 1'b0;
      ped_p_q <= 1'b0;
      pend_q  <= 1'b0;
      blank_q <= 2'd0;
      st_q    <= 1'b0;
      hwy_q   <= GREEN;
      farm_q  <= RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      car_m_q <= car;
      car_s_q <= car_m_q;
      ped_m_q <= ped_req;
      ped_s_q <= ped_m_q;
      ped_p_q <= ped_s_q;
      pend_q  <= pend_d;
      blank_q <= blank_d;
      st_q    <= trans;
      hwy_q   <= hwy_d;
      farm_q  <= farm_d;
      walk_q  <= walk_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:      if (tl_ok & (car_s_q | pend_q)) state_d = HY;
      HY:      if (ts_ok) state_d = pend_q ? PW : FG;
      FG:      if (tl_ok | ~car_s_q) state_d = FY;
      FY:      if (ts_ok) state_d = HG;
      PW:      if (ts_ok) state_d = car_s_q ? FG : HG;
      default: state_d = HG;
    endcase
  end
  // a new press on the PW-entry edge wins over the clear
  always_comb begin
    pend_d  = ped_rise | (pend_q & ~(trans & (state_d == PW)));
    blank_d = trans ? 2'd2 : blank_q - {1'b0, |blank_q};
    hwy_d   = (state_d == HG) ? GREEN : (state_d == HY) ? YELLOW : RED;
    farm_d  = (state_d == FG) ? GREEN : (state_d == FY) ? YELLOW : RED;
    walk_d  = state_d == PW;
  end
  assign st         = st_q;
  assign hwy_light  = hwy_q;
  assign farm_light = farm_q;
  assign walk       = walk_q;
  assign ped_wait   = pend_q;
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of lamp sequencing, timer strobe, masking and pedestrian latching
module tb_traffic_light_controller;
  logic clk = 1'b0;
  logic reset, car, ped_req, ts, tl;
  logic st, walk, ped_wait;
  logic [1:0] hwy_light, farm_light;
  int tests = 0;
  int errs = 0;
  int st_cnt = 0;
  traffic_light_controller dut (
    .clk(clk), .reset(reset), .car(car), .ped_req(ped_req), .ts(ts), .tl(tl),
    .st(st), .hwy_light(hwy_light), .farm_light(farm_light), .walk(walk), .ped_wait(ped_wait)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      st_cnt += int'(st);
    end
  endtask
  task automatic lamps(input string tag, input logic [1:0] h, input logic [1:0] f, input logic w, input logic s);
    check({tag, "_hwy"}, {6'd0, hwy_light}, {6'd0, h});
    check({tag, "_farm"}, {6'd0, farm_light}, {6'd0, f});
    check({tag, "_walk"}, {7'd0, walk}, {7'd0, w});
    check({tag, "_st"}, {7'd0, st}, {7'd0, s});
  endtask
  initial begin
    reset = 1'b1; car = 1'b0; ped_req = 1'b0; ts = 1'b0; tl = 1'b0;
    tick(3);
    lamps("rst", 2'b00, 2'b10, 1'b0, 1'b0);
    check("rst_wait", {7'd0, ped_wait}, 8'd0);
    reset = 1'b0;
    st_cnt = 0;
    tl = 1'b1;
    tick(100);
    tl = 1'b0;
    check("idle_st_cnt", st_cnt[7:0], 8'd0);
    lamps("idle", 2'b00, 2'b10, 1'b0, 1'b0);
    st_cnt = 0;
    car = 1'b1;
    tick(2);
    tl = 1'b1;
    tick(1);
    lamps("hy", 2'b01, 2'b10, 1'b0, 1'b1);
    tick(1);
    lamps("hy_hold1", 2'b01, 2'b10, 1'b0, 1'b0);
    tick(4);
    lamps("hy_hold5", 2'b01, 2'b10, 1'b0, 1'b0);
    tl = 1'b0; ts = 1'b1;
    tick(1);
    lamps("fg", 2'b10, 2'b00, 1'b0, 1'b1);
    tick(3);
    lamps("fg_ts_held", 2'b10, 2'b00, 1'b0, 1'b0);
    ts = 1'b0; car = 1'b0;
    tick(2);
    lamps("fg_car_sync", 2'b10, 2'b00, 1'b0, 1'b0);
    tick(1);
    lamps("fy", 2'b10, 2'b01, 1'b0, 1'b1);
    ts = 1'b1;
    tick(2);
    lamps("fy_blank", 2'b10, 2'b01, 1'b0, 1'b0);
    tick(1);
    lamps("hg_back", 2'b00, 2'b10, 1'b0, 1'b1);
    ts = 1'b0;
    tick(3);
    check("farm_st_cnt", st_cnt[7:0], 8'd4);
    ped_req = 1'b1;
    tick(2);
    check("ped_wait_e2", {7'd0, ped_wait}, 8'd0);
    tick(1);
    check("ped_wait_e3", {7'd0, ped_wait}, 8'd1);
    tick(2);
    ped_req = 1'b0;
    tick(3);
    tl = 1'b1;
    tick(1);
    lamps("ped_hy", 2'b01, 2'b10, 1'b0, 1'b1);
    tl = 1'b0; ts = 1'b1;
    tick(2);
    lamps("ped_hy_blank", 2'b01, 2'b10, 1'b0, 1'b0);
    tick(1);
    lamps("pw", 2'b10, 2'b10, 1'b1, 1'b1);
    check("pw_wait_clr", {7'd0, ped_wait}, 8'd0);
    tick(2);
    lamps("pw_blank", 2'b10, 2'b10, 1'b1, 1'b0);
    tick(1);
    lamps("pw_hg", 2'b00, 2'b10, 1'b0, 1'b1);
    ts = 1'b0;
    tick(3);
    ped_req = 1'b1;
    tick(3);
    ped_req = 1'b0;
    tick(3);
    check("sim_pend", {7'd0, ped_wait}, 8'd1);
    tl = 1'b1;
    tick(1);
    lamps("sim_hy", 2'b01, 2'b10, 1'b0, 1'b1);
    tl = 1'b0; ts = 1'b1; ped_req = 1'b1;
    tick(3);
    lamps("sim_pw", 2'b10, 2'b10, 1'b1, 1'b1);
    check("sim_wait_kept", {7'd0, ped_wait}, 8'd1);
    ped_req = 1'b0;
    tick(3);
    lamps("sim_hg", 2'b00, 2'b10, 1'b0, 1'b1);
    ts = 1'b0;
    tick(2);
    tl = 1'b1;
    tick(1);
    lamps("sim_hy2", 2'b01, 2'b10, 1'b0, 1'b1);
    tl = 1'b0; ts = 1'b1;
    tick(3);
    lamps("sim_pw2", 2'b10, 2'b10, 1'b1, 1'b1);
    check("sim_wait_clr2", {7'd0, ped_wait}, 8'd0);
    ts = 1'b0;
    tick(1);
    reset = 1'b1;
    #2;
    lamps("mid_rst", 2'b00, 2'b10, 1'b0, 1'b0);
    check("mid_rst_wait", {7'd0, ped_wait}, 8'd0);
    tick(2);
    reset = 1'b0;
    car = 1'b1;
    tick(2);
    lamps("post_rst_hg", 2'b00, 2'b10, 1'b0, 1'b0);
    tl = 1'b1;
    tick(1);
    lamps("post_rst_hy", 2'b01, 2'b10, 1'b0, 1'b1);
    tl = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", tests, errs);
    $finish;
  end
endmodule
